// File: rtl/iomem_slot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iomem_slot_ctrl
// Purpose  : Shares the picosoc iomem bus between page-mapped valid/ready
//            slave slots. A per-access timeout and a bus-error interrupt
//            keep a dead or unmapped slot from stalling the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module iomem_slot_ctrl #(
  parameter int          NSLOTS    = 8,
  parameter logic [7:0]  BASE_PAGE = 8'h03,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic [3:0]           m_wstrb,
  input  logic [31:0]          m_addr,
  input  logic [31:0]          m_wdata,
  output logic [31:0]          m_rdata,
  output logic [NSLOTS-1:0]    s_valid,
  input  logic [NSLOTS-1:0]    s_ready,
  input  logic [NSLOTS*32-1:0] s_rdata,
  output logic [31:0]          s_addr,
  output logic [3:0]           s_wstrb,
  output logic [31:0]          s_wdata,
  output logic                 err_irq,
  output logic [31:0]          err_addr
);

  localparam int IDXW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ERR  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDXW-1:0]   r_idx;
  logic [15:0]       r_cnt;
  logic [7:0]        w_page_idx;
  logic              w_mapped;
  logic              w_sel_ready;
  logic [31:0]       w_sel_rdata;
  logic              w_expired;

  // Pages below BASE_PAGE wrap to large indices and therefore fall out of range.
  assign w_page_idx = m_addr[31:24] - BASE_PAGE;
  assign w_mapped   = (w_page_idx < 8'(NSLOTS));
  assign w_expired  = (r_cnt == 16'(TIMEOUT - 1));

  // Only the selected slot's ready and data are looked at.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = 32'd0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_sel_ready = s_ready[i];
        w_sel_rdata = s_rdata[i*32 +: 32];
      end
    end
  end

  // Decoded from state so that an asynchronous reset drops it at once.
  always_comb begin
    s_valid = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      s_valid[i] = (r_state == ST_REQ) && (r_idx == IDXW'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    m_ready = 1'b0;
    err_irq = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m_valid) begin
          w_next = w_mapped ? ST_REQ : ST_ERR;
        end
      end
      ST_REQ: begin
        if (w_sel_ready) begin
          w_next = ST_DONE;
        end else if (w_expired) begin
          w_next = ST_ERR;
        end
      end
      ST_ERR: begin
        err_irq = 1'b1;
        w_next  = ST_DONE;
      end
      ST_DONE: begin
        m_ready = 1'b1;
        w_next  = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx    <= '0;
      r_cnt    <= 16'd0;
      m_rdata  <= 32'd0;
      s_addr   <= 32'd0;
      s_wstrb  <= 4'd0;
      s_wdata  <= 32'd0;
      err_addr <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Latched for unmapped pages too, so ERR can report the address.
          if (m_valid) begin
            s_addr  <= m_addr;
            s_wstrb <= m_wstrb;
            s_wdata <= m_wdata;
            r_idx   <= w_page_idx[IDXW-1:0];
            r_cnt   <= 16'd0;
          end
        end
        ST_REQ: begin
          if (r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
          end
          if (w_sel_ready) begin
            m_rdata <= w_sel_rdata;
          end
        end
        ST_ERR: begin
          m_rdata  <= ERR_DATA;
          err_addr <= s_addr;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
